// File: rtl/adder_pipe_result_fifo.sv
// adder_pipe_result_fifo: FWFT result FIFO behind a non-stalling adder, with issue credit and sticky error flags
module adder_pipe_result_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue,
  output logic                  issue_ok,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH:0]   in_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH:0]   out_data,
  output logic [CNT_W-1:0]      count,
  output logic                  ovf_err,
  output logic                  proto_err
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_WIDTH:0] mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d, in_flight_q, in_flight_d;
  logic                ovf_err_q, ovf_err_d, proto_err_q, proto_err_d;
  logic                pop, push, full, dec, inc;
  always_comb begin
    full        = count_q == CNT_W'(DEPTH);
    pop         = (count_q != '0) && out_ready;
    push        = in_valid && (!full || pop);
    dec         = in_valid && (in_flight_q != '0);
    inc         = issue && (in_flight_q != CNT_W'(DEPTH));
    wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d     = (push && !pop) ? count_q + CNT_W'(1) :
                  (pop && !push) ? count_q - CNT_W'(1) : count_q;
    in_flight_d = (inc && !dec) ? in_flight_q + CNT_W'(1) :
                  (dec && !issue) ? in_flight_q - CNT_W'(1) : in_flight_q;
    ovf_err_d   = ovf_err_q || (in_valid && full && !pop);
    proto_err_d = proto_err_q || (issue && !issue_ok) || (in_valid && in_flight_q == '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_flight_q <= '0;
      ovf_err_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_flight_q <= in_flight_d;
      ovf_err_q   <= ovf_err_d;
      proto_err_q <= proto_err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= in_result;
  end
  // credit covers stored entries plus results still inside the adder
  assign issue_ok  = ({1'b0, count_q} + {1'b0, in_flight_q}) < (CNT_W + 1)'(DEPTH);
  assign out_valid = count_q != '0;
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign ovf_err   = ovf_err_q;
  assign proto_err = proto_err_q;
endmodule

// File: tb/tb_adder_pipe_result_fifo.sv
// tb_adder_pipe_result_fifo: directed checks of FIFO ordering, credit, overflow, protocol errors and reset
module tb_adder_pipe_result_fifo;
  logic        clk = 0, rst = 0, issue = 0, in_valid = 0, out_ready = 0;
  logic [64:0] in_result = '0;
  logic        issue_ok, out_valid, ovf_err, proto_err;
  logic [64:0] out_data;
  logic [3:0]  count;
  int          total = 0, bad = 0;

  adder_pipe_result_fifo dut (
    .clk(clk), .rst(rst), .issue(issue), .issue_ok(issue_ok),
    .in_valid(in_valid), .in_result(in_result), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .count(count),
    .ovf_err(ovf_err), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1;
    cyc();
    rst = 0;
  endtask

  task automatic fill(input int lo, input int hi);
    issue = 1;
    repeat (hi - lo + 1) cyc();
    issue = 0;
    for (int v = lo; v <= hi; v++) begin
      in_valid = 1;
      in_result = 65'(v);
      cyc();
    end
    in_valid = 0;
  endtask

  task automatic drain(input int lo, input int hi);
    out_ready = 1;
    for (int v = lo; v <= hi; v++) begin
      chk("drain_valid", out_valid, 1);
      chk("drain_data", out_data, 65'(v));
      cyc();
    end
    out_ready = 0;
    chk("drain_empty", count, 0);
  endtask

  initial begin
    do_reset();
    chk("rst_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_issue_ok", issue_ok, 1);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_proto", proto_err, 0);
    // single add with carry-out
    issue = 1;
    cyc();
    issue = 0;
    repeat (3) cyc();
    in_valid = 1;
    in_result = 65'h1_0000_0000_0000_0000;
    cyc();
    in_valid = 0;
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 65'h1_0000_0000_0000_0000);
    chk("t1_count", count, 1);
    out_ready = 1;
    cyc();
    out_ready = 0;
    chk("t1_pop_count", count, 0);
    chk("t1_pop_valid", out_valid, 0);
    // credit exhaustion with 8 in flight
    issue = 1;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      chk("t2_issue_ok", issue_ok, i < 8);
    end
    issue = 0;
    for (int v = 1; v <= 8; v++) begin
      in_valid = 1;
      in_result = 65'(v);
      cyc();
    end
    in_valid = 0;
    chk("t2_count", count, 8);
    chk("t2_issue_ok_full", issue_ok, 0);
    drain(1, 8);
    chk("t2_ovf", ovf_err, 0);
    chk("t2_proto", proto_err, 0);
    chk("t2_issue_ok_after", issue_ok, 1);
    // overflow drop
    fill(1, 8);
    in_valid = 1;
    in_result = 65'd9;
    cyc();
    in_valid = 0;
    chk("t3_ovf", ovf_err, 1);
    chk("t3_count", count, 8);
    drain(1, 8);
    chk("t3_ovf_sticky", ovf_err, 1);
    // full with simultaneous push and pop
    do_reset();
    fill(1, 8);
    in_valid = 1;
    in_result = 65'd9;
    out_ready = 1;
    cyc();
    in_valid = 0;
    out_ready = 0;
    chk("t4_count", count, 8);
    chk("t4_head", out_data, 65'd2);
    chk("t4_ovf", ovf_err, 0);
    drain(2, 9);
    // protocol errors
    do_reset();
    fill(1, 8);
    chk("t5_proto_before", proto_err, 0);
    issue = 1;
    cyc();
    issue = 0;
    chk("t5_proto_issue", proto_err, 1);
    do_reset();
    in_valid = 1;
    in_result = 65'd5;
    cyc();
    in_valid = 0;
    chk("t5_proto_noflight", proto_err, 1);
    chk("t5_count", count, 1);
    chk("t5_inflight_zero", issue_ok, 1);
    // streaming wrap-around
    do_reset();
    issue = 1;
    cyc();
    out_ready = 1;
    for (int i = 1; i <= 20; i++) begin
      in_valid = 1;
      in_result = 65'(i) | (65'(i & 1) << 64);
      cyc();
      chk("t6_valid", out_valid, 1);
      chk("t6_data", out_data, 65'(i) | (65'(i & 1) << 64));
      chk("t6_count", count, 1);
    end
    issue = 0;
    in_valid = 0;
    cyc();
    out_ready = 0;
    chk("t6_empty", count, 0);
    chk("t6_ovf", ovf_err, 0);
    chk("t6_proto", proto_err, 0);
    issue = 1;
    repeat (2) cyc();
    issue = 0;
    for (int v = 1; v <= 3; v++) begin
      in_valid = 1;
      in_result = 65'(v);
      cyc();
    end
    in_valid = 0;
    chk("t6_count3", count, 3);
    do_reset();
    chk("t6_rst_count", count, 0);
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_issue_ok", issue_ok, 1);
    chk("t6_rst_ovf", ovf_err, 0);
    chk("t6_rst_proto", proto_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adder_pipe_result_fifo.md
Name: adder_pipe_result_fifo

Overview:
- Downstream consumer of the 64-bit pipelined adder.
- Captures each {carry, sum} result qualified by the adder's o_en into a small FIFO, and presents it to the next stage on a valid/ready handshake.
- The adder cannot stall, so the block also issues a credit (issue_ok) to the operand source. It counts results already in the FIFO plus operations in flight in the adder, so no result is ever dropped when the source obeys issue_ok.

Parameters:
- DATA_WIDTH, 64, adder operand width; result/entry width is DATA_WIDTH+1.
- DEPTH, 8, FIFO entries; power of two, 2..64.
- CNT_W, 4, counter width; must hold 0..DEPTH inclusive (clog2(DEPTH)+1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- issue  in  1  pulse, same cycle the operand source drives the adder's i_en high.
- issue_ok  out  1  credit: source may assert issue this cycle.
- in_valid  in  1  from adder o_en.
- in_result  in  DATA_WIDTH+1  from adder result; MSB is carry-out.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_WIDTH+1  FIFO head entry.
- count  out  CNT_W  entries currently stored.
- ovf_err  out  1  sticky: in_valid arrived with FIFO full and no pop.
- proto_err  out  1  sticky: issue while issue_ok low, or in_valid with zero in flight.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst=1 at a clock edge): pointers, count, in_flight, ovf_err and proto_err all cleared; out_valid=0; issue_ok=1 after the edge.
  - out_data is undefined while out_valid=0.
  - Reset mid-operation discards stored entries and the in-flight count. The source must also reset the adder.
- Storage: circular buffer of DEPTH entries, wr_ptr/rd_ptr of clog2(DEPTH) bits, wrapping naturally at DEPTH-1 -> 0.
- Output is first-word-fall-through:
  - out_data = mem[rd_ptr].
  - out_valid = (count != 0).
  - Both are registered-state driven, with no combinational path from in_* to out_*.
- Push: when in_valid=1 and (count<DEPTH or pop this cycle), write in_result at wr_ptr and increment wr_ptr.
- Pop: when out_valid=1 and out_ready=1, increment rd_ptr.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency: an in_valid written to an empty FIFO at edge N gives out_valid=1 and out_data=that result after edge N (visible in cycle N+1).
- Full, simultaneous push+pop: both accepted; count stays DEPTH.
- Full, push without pop: entry dropped; ovf_err set; count and memory unchanged.
- Empty, out_ready=1: no effect.
- in_flight counter, range 0..DEPTH:
  - +1 on issue, -1 on in_valid.
  - Unchanged when both occur in the same cycle.
  - in_valid with in_flight=0 sets proto_err and does not decrement.
- issue_ok = (count + in_flight) < DEPTH, computed from registered count/in_flight only. Pops in the current cycle are not credited until the next cycle.
- issue while issue_ok=0: proto_err set; in_flight still increments, saturating at DEPTH.
- Error flags clear only on rst.
- Width: in_result stored unmodified; carry-out (bit DATA_WIDTH) preserved end to end.

Test Plan:
1. Reset, then issue one add, and 4 cycles later in_valid with in_result=65'h1_0000_0000_0000_0000 (all-ones + 1) -> out_valid the next cycle, out_data=65'h1_0000_0000_0000_0000, count=1; pop -> count=0, out_valid=0.
2. out_ready=0, issue 8 ops back-to-back, then deliver results 1..8 -> issue_ok falls to 0 after the 8th issue; count=8; draining yields 1..8 in order with no errors.
3. Full FIFO (values 1..8): inject in_valid with value 9, out_ready=0 -> ovf_err=1, count=8, drained sequence is still 1..8.
4. Full FIFO: in_valid with value 9 and out_ready=1 in the same cycle -> count stays 8, head becomes 2, no ovf_err; drain gives 2..9.
5. Issue with issue_ok=0 -> proto_err=1. Separately, in_valid with in_flight=0 -> proto_err=1 and in_flight stays 0.
6. Wrap-around: stream 20 results with out_ready held at 1 -> each appears one cycle after its in_valid, in order, with count never above 1 and no errors. Then assert rst with count=3 -> after the edge count=0, out_valid=0, issue_ok=1, and both error flags are 0.
